// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: load/store opcodes, M-stage forwarding
// selects and the default data-memory depth.
package mips_pkg;

  localparam int DM_WORDS_DEF = 1024;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [2:0] FWD_RTM_REG = 3'd0;
  localparam logic [2:0] FWD_RTM_WDW = 3'd1;

endpackage

// File: rtl/mem_stage_if.sv
// EX -> MEM bundle plus M-stage outputs toward EX forwarding and MEM/WB.
// master is the surrounding pipeline, slave is mem_stage.
interface mem_stage_if;

  logic        clr_M;
  logic [31:0] Instr_E_in;
  logic [31:0] ALUout_E;
  logic [31:0] RT_E_in;
  logic [4:0]  A3_E_in;
  logic [31:0] PC4_E_in;
  logic [31:0] PC8_E_in;
  logic [31:0] WD_W;
  logic [2:0]  ForwardRTM;

  logic [31:0] Instr_M_out;
  logic [31:0] ALUout_M;
  logic [4:0]  A3_M_out;
  logic [31:0] PC4_M_out;
  logic [31:0] PC8_M_out;
  logic [31:0] DMout_M;

  modport master (
    output clr_M, Instr_E_in, ALUout_E, RT_E_in,
    output A3_E_in, PC4_E_in, PC8_E_in, WD_W, ForwardRTM,
    input  Instr_M_out, ALUout_M, A3_M_out,
    input  PC4_M_out, PC8_M_out, DMout_M
  );

  modport slave (
    input  clr_M, Instr_E_in, ALUout_E, RT_E_in,
    input  A3_E_in, PC4_E_in, PC8_E_in, WD_W, ForwardRTM,
    output Instr_M_out, ALUout_M, A3_M_out,
    output PC4_M_out, PC8_M_out, DMout_M
  );

endinterface

// File: rtl/dm_bytewrite.sv
// Word-organised data memory with byte-enable write and combinational read.
// DM_WRITE_LOG_EN prints each committed store with its merged word.
module dm_bytewrite
  import mips_pkg::*;
#(
  parameter int WORDS = DM_WORDS_DEF,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [31:0]   log_pc,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] merged;

  assign rdata = mem[addr];

  always_comb begin
    merged = rdata;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  // reset wipes the array and drops any store on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (|be) begin
      mem[addr] <= merged;
`ifdef DM_WRITE_LOG_EN
      $display("%d@%h: *%h <= %h", $time, log_pc - 32'd4,
               32'({addr, 2'b00}), merged);
`endif
    end
  end

`ifndef DM_WRITE_LOG_EN
  logic unused_log_pc;
  assign unused_log_pc = ^log_pc;
`endif

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, RT store forwarding, byte-lane
// store steering, DM and load extension. Optional log: DM_WRITE_LOG_EN.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  m
);

  logic [31:0] instr_q;
  logic [31:0] alu_q;
  logic [31:0] rt_q;
  logic [4:0]  a3_q;
  logic [31:0] pc4_q;
  logic [31:0] pc8_q;

  always_ff @(posedge clk) begin
    if (reset || m.clr_M) begin
      instr_q <= '0;
      alu_q   <= '0;
      rt_q    <= '0;
      a3_q    <= '0;
      pc4_q   <= '0;
      pc8_q   <= '0;
    end else begin
      instr_q <= m.Instr_E_in;
      alu_q   <= m.ALUout_E;
      rt_q    <= m.RT_E_in;
      a3_q    <= m.A3_E_in;
      pc4_q   <= m.PC4_E_in;
      pc8_q   <= m.PC8_E_in;
    end
  end

  assign m.Instr_M_out = instr_q;
  assign m.ALUout_M    = alu_q;
  assign m.A3_M_out    = a3_q;
  assign m.PC4_M_out   = pc4_q;
  assign m.PC8_M_out   = pc8_q;

  logic [5:0] op;
  logic is_lw, is_lh, is_lhu, is_lb, is_lbu;
  logic is_sw, is_sh, is_sb;

  assign op     = instr_q[31:26];
  assign is_lw  = (op == OP_LW);
  assign is_lh  = (op == OP_LH);
  assign is_lhu = (op == OP_LHU);
  assign is_lb  = (op == OP_LB);
  assign is_lbu = (op == OP_LBU);
  assign is_sw  = (op == OP_SW);
  assign is_sh  = (op == OP_SH);
  assign is_sb  = (op == OP_SB);

  logic [31:0] wsrc;
  logic [31:0] wlane;
  logic [3:0]  be;

  assign wsrc = (m.ForwardRTM == FWD_RTM_WDW) ? m.WD_W : rt_q;

  // data is replicated across lanes; be picks which lanes land
  always_comb begin
    be    = 4'b0000;
    wlane = wsrc;
    unique case (1'b1)
      is_sw: begin
        be    = 4'b1111;
        wlane = wsrc;
      end
      is_sh: begin
        be    = alu_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wsrc[15:0]}};
      end
      is_sb: begin
        be    = 4'b0001 << alu_q[1:0];
        wlane = {4{wsrc[7:0]}};
      end
      default: begin
        be    = 4'b0000;
        wlane = wsrc;
      end
    endcase
  end

  logic [DM_AW-1:0] idx;
  logic [31:0]      rword;

  assign idx = alu_q[DM_AW+1:2];

  dm_bytewrite #(
    .WORDS (DM_WORDS),
    .AW    (DM_AW)
  ) u_dm (
    .clk    (clk),
    .reset  (reset),
    .be     (be),
    .addr   (idx),
    .wdata  (wlane),
    .log_pc (pc4_q),
    .rdata  (rword)
  );

  logic [15:0] half;
  logic [7:0]  byte_sel;
  logic [31:0] dm_out;

  assign half     = alu_q[1] ? rword[31:16] : rword[15:0];
  assign byte_sel = rword[{alu_q[1:0], 3'b000} +: 8];

  always_comb begin
    dm_out = '0;
    unique case (1'b1)
      is_lw:   dm_out = rword;
      is_lh:   dm_out = {{16{half[15]}}, half};
      is_lhu:  dm_out = {16'h0, half};
      is_lb:   dm_out = {{24{byte_sel[7]}}, byte_sel};
      is_lbu:  dm_out = {24'h0, byte_sel};
      default: dm_out = '0;
    endcase
  end

  assign m.DMout_M = dm_out;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline, directly downstream of EX.
- Contains the EX/MEM pipeline register, the M-stage RT forwarding mux, a byte-addressable data memory (DM), and load extraction with sign/zero extension.
- Its registered ALU result feeds EX forwarding as ALUout_M; its outputs feed the MEM/WB register.

Parameters:
- DM_WORDS, 1024, number of 32-bit DM words (4 KB); word index = ALUout_M[11:2] for the default.
- DM_AW, 10, DM word-address width; must equal log2(DM_WORDS).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high; clears pipeline register and DM.
- clr_M  in  1  synchronous bubble insert; M register loads NOP (used while XALU busy stalls E).
- Instr_E_in  in  32  instruction leaving EX.
- ALUout_E  in  32  EX result (ALU/PC8/HI/LO already selected).
- RT_E_in  in  32  forwarded RT from EX (store data).
- A3_E_in  in  5  destination register.
- PC4_E_in  in  32  PC+4 of instruction.
- PC8_E_in  in  32  PC+8 of instruction.
- WD_W  in  32  write-back data for M-stage forwarding.
- ForwardRTM  in  3  0: registered RT; 1: WD_W; other values: registered RT.
- Instr_M_out  out  32  registered instruction.
- ALUout_M  out  32  registered EX result; DM byte address; forwarded to EX.
- A3_M_out  out  5  registered destination.
- PC4_M_out  out  32  registered PC+4.
- PC8_M_out  out  32  registered PC+8.
- DMout_M  out  32  extended load data; combinational from DM and M register.

Behaviour:
- Clocking: one clock; reset is synchronous, active-high; clk and reset as named above.
- M register on posedge clk:
  - reset=1 or clr_M=1: Instr, ALUout, RT, A3, PC4 and PC8 are all 0. Instr 0 is sll $0 = NOP.
  - Otherwise all six fields capture their E inputs.
  - reset has priority over clr_M.
- Reset values: all M outputs 0; DMout_M 0, since Instr=0 is not a load.
- Store data: WDATA = (ForwardRTM==1) ? WD_W : RT_M.
- Opcode = Instr_M[31:26].
- Stores write DM at the posedge ending the instruction's M cycle; latency 1; visible to a load in M the next cycle.
  - sw (0x2B): write all 4 bytes; ALUout_M[1:0] ignored.
  - sh (0x29): ALUout_M[1]=0 writes bytes 1:0 with WDATA[15:0]; =1 writes bytes 3:2.
  - sb (0x28): byte ALUout_M[1:0] gets WDATA[7:0]; other bytes unchanged.
- Word index = ALUout_M[DM_AW+1:2]; higher address bits are ignored, so addresses wrap modulo DM size.
- Reset clears all DM words to 0 on the same edge. A store present during reset is discarded.
- Loads are combinational from the current DM word W = DM[index]:
  - lw (0x23): W.
  - lh (0x21) / lhu (0x25): half selected by ALUout_M[1], sign- or zero-extended.
  - lb (0x20) / lbu (0x24): byte selected by ALUout_M[1:0], sign- or zero-extended.
  - Any other opcode: DMout_M = 0.
- Only one DM access occurs per cycle, since M holds a single instruction; no read/write conflict exists.
- clr_M on the edge of a store in M: the store still commits (it is in M this cycle); the next M content is NOP.
- No exception or alignment trap; misaligned low bits are handled as above.

Optional Feature:
- Macro: DM_WRITE_LOG_EN.
- Defined: every committed store prints `$display("%d@%h: *%h <= %h", $time, PC4_M-4, {index,2'b00}, merged_word)` at the write edge. merged_word is the full word after byte merge.
- Undefined: no display; hardware identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB;
  - FWD_RTM_REG=0 and FWD_RTM_WDW=1;
  - the DM_WORDS default.
- One sub-module, dm_bytewrite:
  - word array with a 4-bit byte-enable write port and a combinational read port;
  - synchronous clear on reset;
  - contains the logging hook.
- Byte-enable generation and load extension stay in mem_stage.

Test Plan:
- Reset for 1 cycle, then lw from 0x0 -> DMout_M=0, all M outputs 0 during and after the reset edge.
- sw 0x12345678 @0x10, next cycle lw @0x10 -> 0x12345678; lb @0x13 -> 0x00000012; lbu @0x10 -> 0x00000078.
- sh 0xFFFF85A0 @0x22, then lh @0x22 -> 0xFFFF85A0; lhu @0x22 -> 0x000085A0; lw @0x20 -> 0x85A00000.
- sb with ForwardRTM=1, RT_M=0x11, WD_W=0xAB @0x7 -> word @0x4 becomes 0xAB000000; then ForwardRTM=2 uses RT_M.
- clr_M=1 while a lw sits in E -> next cycle Instr_M_out=0, A3_M_out=0, DMout_M=0; the preceding store still committed.
- Address wrap: sw 0xCAFEBABE @0x1004 -> lw @0x4 returns 0xCAFEBABE. With DM_WRITE_LOG_EN the printed line shows `*00000004 <= cafebabe`.
